// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product bundle for the sequential shift-add multiplier.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high; the
// producer holds its payload stable while valid is high, and ready never depends on valid.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic [1:0]         state;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy, state
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy, state
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle WIDTH x WIDTH multiplier retiring STEP multiplier bits per clock.
// Operates on magnitudes and applies the sign once at the end, so signed and unsigned share one datapath.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     product_q;
  logic [CW-1:0]     count;
  logic              neg;

  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     sum;
  logic [PW-1:0]     result;
  logic              accept;
  logic              last;

  // 2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) a_mag = (~bus.a) + WIDTH'(1'b1);
    if (bus.signed_mode && bus.b[WIDTH-1]) b_mag = (~bus.b) + WIDTH'(1'b1);
  end

  // mcand is pre-shifted each cycle, so the low STEP bits of mplier select shifted copies of it.
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
    sum    = acc + pp;
    result = neg ? ((~sum) + PW'(1'b1)) : sum;
  end

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.product = product_q;
  assign bus.state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      product_q <= '0;
      count     <= '0;
      neg       <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        count  <= '0;
        neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end else if (state == BUSY) begin
        acc    <= sum;
        mcand  <= mcand << STEP;
        mplier <= mplier >> STEP;
        count  <= count + CW'(1);
        if (last) product_q <= result;
      end
    end
  end

endmodule
